depacketizer_vc_sched: RTL and testbench

DEPACKETIZER_VC_SCHED -- requirements
Module: depacketizer_vc_sched

---
 rtl/depacketizer_pkg.sv | 14 +
 rtl/depacketizer_vc_sched_if.sv | 12 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/depacketizer_vc_sched.sv | 126 ++++++++++++
 tb/tb_depacketizer_vc_sched.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/depacketizer_pkg.sv
// rtl/depacketizer_pkg.sv - shared flit field positions and VC count derivation
package depacketizer_pkg;

  // Field positions are offsets down from the flit MSB, so they hold for any flit width
  localparam int FLIT_VALID_OFS = 1;
  localparam int FLIT_HEAD_OFS  = 2;
  localparam int FLIT_TAIL_OFS  = 3;
  localparam int FLIT_VC_OFS    = 4;

  function automatic int num_vc(input int vc_address_width);
    return 1 << vc_address_width;
  endfunction

endpackage

// File: rtl/depacketizer_vc_sched_if.sv
// rtl/depacketizer_vc_sched_if.sv - packet output handshake towards the downstream depacketizer
interface depacketizer_vc_sched_if #(
  parameter int WIDTH_PKT        = 36,
  parameter int VC_ADDRESS_WIDTH = 1
);
  logic [WIDTH_PKT-1:0]        pkt_out;
  logic [VC_ADDRESS_WIDTH-1:0] vc_out;
  logic                        ready_in;

  modport master (output pkt_out, output vc_out, input ready_in);
  modport slave  (input pkt_out, input vc_out, output ready_in);
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter, one-hot grant, pointer moves past the winner on enable
module rr_arbiter #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] grant,
  output logic [W-1:0] winner,
  output logic         any
);
  logic [W-1:0] ptr;

  always_comb begin
    grant  = '0;
    winner = '0;
    any    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any && req[ptr + W'(i)]) begin
        any    = 1'b1;
        winner = ptr + W'(i);
      end
    end
    if (any) grant[winner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (en && any) begin
      ptr <= winner + W'(1);
    end
  end
endmodule

// File: rtl/depacketizer_vc_sched.sv
// rtl/depacketizer_vc_sched.sv - reassembles head/tail flit pairs per VC into packets
// and schedules the per-VC packet FIFOs round-robin onto one registered output.
module depacketizer_vc_sched
  import depacketizer_pkg::*;
#(
  parameter int WIDTH_PKT        = 36,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int BUF_DEPTH        = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [WIDTH_PKT/2-1:0]              flit_in,
  output logic [num_vc(VC_ADDRESS_WIDTH)-1:0] credit_out,
  depacketizer_vc_sched_if.master             pkt_if,
  output logic                                err_protocol,
  output logic                                err_overflow
);
  localparam int WF     = WIDTH_PKT / 2;
  localparam int NUM_VC = num_vc(VC_ADDRESS_WIDTH);
  localparam int AW     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW     = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(BUF_DEPTH);

  logic                        f_valid;
  logic                        f_head;
  logic                        f_tail;
  logic [VC_ADDRESS_WIDTH-1:0] f_vc;

  assign f_valid = flit_in[WF-FLIT_VALID_OFS];
  assign f_head  = flit_in[WF-FLIT_HEAD_OFS];
  assign f_tail  = flit_in[WF-FLIT_TAIL_OFS];
  assign f_vc    = flit_in[WF-FLIT_VC_OFS -: VC_ADDRESS_WIDTH];

  logic [NUM_VC-1:0]    hold_full;
  logic [WF-1:0]        hold_flit [NUM_VC];
  logic [WIDTH_PKT-1:0] mem       [NUM_VC][BUF_DEPTH];
  logic [AW-1:0]        wr_ptr    [NUM_VC];
  logic [AW-1:0]        rd_ptr    [NUM_VC];
  logic [CW-1:0]        count     [NUM_VC];

  logic                        hold_hit;
  logic                        proto_err;
  logic                        store_head;
  logic                        complete;
  logic                        push;
  logic                        overflow;
  logic                        load;
  logic                        any_req;
  logic [NUM_VC-1:0]           req;
  logic [NUM_VC-1:0]           grant;
  logic [NUM_VC-1:0]           pop;
  logic [NUM_VC-1:0]           push_vec;
  logic [VC_ADDRESS_WIDTH-1:0] winner;

  assign hold_hit   = hold_full[f_vc];
  assign proto_err  = f_valid & ((f_head & f_tail) | (f_tail & ~hold_hit) | (f_head & hold_hit));
  assign store_head = f_valid & f_head & ~f_tail & ~hold_hit;
  assign complete   = f_valid & f_tail & ~f_head & hold_hit;

  // The output register is empty exactly when its packet-valid bit (head flit valid) is clear
  assign load = ~pkt_if.pkt_out[WIDTH_PKT-1] | pkt_if.ready_in;

  always_comb begin
    req = '0;
    for (int v = 0; v < NUM_VC; v++) req[v] = (count[v] != '0);
  end

  rr_arbiter #(
    .N (NUM_VC),
    .W (VC_ADDRESS_WIDTH)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .en     (load),
    .grant  (grant),
    .winner (winner),
    .any    (any_req)
  );

  assign pop = load ? grant : '0;

  // A same-cycle pop frees the slot, so a full FIFO still accepts the completing tail
  assign push     = complete & ((count[f_vc] != FULL_COUNT) | pop[f_vc]);
  assign overflow = complete & (count[f_vc] == FULL_COUNT) & ~pop[f_vc];
  assign push_vec = push ? (NUM_VC'(1) << f_vc) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full <= '0;
      for (int v = 0; v < NUM_VC; v++) begin
        hold_flit[v] <= '0;
        wr_ptr[v]    <= '0;
        rd_ptr[v]    <= '0;
        count[v]     <= '0;
      end
      pkt_if.pkt_out <= '0;
      pkt_if.vc_out  <= '0;
      credit_out     <= '0;
      err_protocol   <= 1'b0;
      err_overflow   <= 1'b0;
    end else begin
      credit_out <= pop;
      if (proto_err) err_protocol <= 1'b1;
      if (overflow)  err_overflow <= 1'b1;
      if (store_head) begin
        hold_full[f_vc] <= 1'b1;
        hold_flit[f_vc] <= flit_in;
      end
      if (complete) hold_full[f_vc] <= 1'b0;
      for (int v = 0; v < NUM_VC; v++) begin
        if (push_vec[v]) wr_ptr[v] <= wr_ptr[v] + AW'(1);
        if (pop[v])      rd_ptr[v] <= rd_ptr[v] + AW'(1);
        count[v] <= count[v] + CW'(push_vec[v]) - CW'(pop[v]);
      end
      if (load) begin
        pkt_if.pkt_out <= any_req ? mem[winner][rd_ptr[winner]] : '0;
        pkt_if.vc_out  <= any_req ? winner : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[f_vc][wr_ptr[f_vc]] <= {hold_flit[f_vc], flit_in};
  end
endmodule

// File: tb/tb_depacketizer_vc_sched.sv
// tb/tb_depacketizer_vc_sched.sv - directed table, corner sequences and randomized
// traffic against a queue-based reference of the depacketizer scheduler.
module tb_depacketizer_vc_sched;
  localparam int WP    = 36;
  localparam int WF    = 18;
  localparam int VAW   = 1;
  localparam int NV    = 2;
  localparam int DEPTH = 2;

  typedef logic [WP-1:0] pkt_t;
  typedef logic [WF-1:0] flit_t;

  typedef struct {
    flit_t      flit;
    logic       rdy;
    pkt_t       pkt;
    logic       vc;
    logic [1:0] cred;
    logic       perr;
    logic       oerr;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  flit_t         flit_in = '0;
  logic [NV-1:0] credit_out;
  logic          err_protocol;
  logic          err_overflow;

  depacketizer_vc_sched_if #(.WIDTH_PKT(WP), .VC_ADDRESS_WIDTH(VAW)) pkt_if ();

  depacketizer_vc_sched #(
    .WIDTH_PKT        (WP),
    .VC_ADDRESS_WIDTH (VAW),
    .BUF_DEPTH        (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flit_in      (flit_in),
    .credit_out   (credit_out),
    .pkt_if       (pkt_if.master),
    .err_protocol (err_protocol),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference state: partial packet per VC, packet queue per VC, output register
  pkt_t       m_fq [NV][$];
  bit         m_hold_v [NV];
  flit_t      m_hold_f [NV];
  int         m_rr;
  pkt_t       m_out;
  int         m_vc;
  logic [1:0] m_cred;
  bit         m_perr;
  bit         m_oerr;

  function automatic flit_t mk(input bit h, input bit t, input bit vc, input logic [13:0] pl);
    return {1'b1, h, t, vc, pl};
  endfunction

  function automatic vec_t row(input flit_t f, input pkt_t p, input logic vc,
                               input logic [1:0] c, input logic pe);
    return '{f, 1'b1, p, vc, c, pe, 1'b0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_edge(input flit_t f, input logic rdy, input logic r);
    int   pop_vc;
    int   v;
    bit   load;
    bit   do_push;
    pkt_t np;
    pop_vc  = -1;
    v       = 0;
    do_push = 0;
    np      = '0;
    if (r) begin
      for (int i = 0; i < NV; i++) begin
        m_fq[i].delete();
        m_hold_v[i] = 0;
      end
      m_rr = 0; m_out = '0; m_vc = 0; m_cred = '0; m_perr = 0; m_oerr = 0;
      return;
    end
    load = !m_out[WP-1] || rdy;
    if (load)
      for (int i = 0; i < NV; i++)
        if (pop_vc < 0 && m_fq[(m_rr + i) % NV].size() > 0) pop_vc = (m_rr + i) % NV;
    if (f[WF-1]) begin
      v = int'(f[WF-4]);
      if ((f[WF-2] && f[WF-3]) || (f[WF-3] && !m_hold_v[v]) || (f[WF-2] && m_hold_v[v])) begin
        m_perr = 1;
      end else if (f[WF-2]) begin
        m_hold_v[v] = 1;
        m_hold_f[v] = f;
      end else if (f[WF-3]) begin
        m_hold_v[v] = 0;
        np = {m_hold_f[v], f};
        if (m_fq[v].size() < DEPTH || pop_vc == v) do_push = 1;
        else m_oerr = 1;
      end
    end
    m_cred = '0;
    if (load) begin
      if (pop_vc >= 0) begin
        m_out = m_fq[pop_vc].pop_front();
        m_vc  = pop_vc;
        m_rr  = (pop_vc + 1) % NV;
        m_cred[pop_vc] = 1'b1;
      end else begin
        m_out = '0;
      end
    end
    if (do_push) m_fq[v].push_back(np);
  endtask

  task automatic cmp_model();
    check("model_pkt", 64'(pkt_if.pkt_out), 64'(m_out));
    if (m_out[WP-1]) check("model_vc", 64'(pkt_if.vc_out), 64'(m_vc));
    check("model_credit", 64'(credit_out), 64'(m_cred));
    check("model_err_protocol", 64'(err_protocol), 64'(m_perr));
    check("model_err_overflow", 64'(err_overflow), 64'(m_oerr));
  endtask

  task automatic step(input flit_t f, input logic rdy, input logic r);
    flit_in = f;
    pkt_if.ready_in = rdy;
    rst = r;
    @(posedge clk);
    model_edge(f, rdy, r);
    #1;
    cmp_model();
  endtask

  task automatic run_random(input int n, input int ready_pct);
    flit_t f;
    logic  rdy;
    logic  r;
    int    v;
    int    k;
    for (int c = 0; c < n; c++) begin
      r   = ($urandom_range(0, 299) == 0);
      rdy = ($urandom_range(0, 99) < ready_pct);
      f   = '0;
      if ($urandom_range(0, 9) < 7) begin
        v = $urandom_range(0, NV - 1);
        k = $urandom_range(0, 19);
        if (k == 0)      f = mk(1'b1, 1'b1, v[0], 14'($urandom));
        else if (k == 1) f = mk(m_hold_v[v], !m_hold_v[v], v[0], 14'($urandom));
        else             f = mk(!m_hold_v[v], m_hold_v[v], v[0], 14'($urandom));
      end
      step(f, rdy, r);
    end
  endtask

  initial begin
    vec_t tbl [14];
    int   order [$];
    int   exp_order [5] = '{0, 1, 0, 1, 0};

    tbl[0]  = row(mk(1'b1, 1'b0, 1'b0, 14'h0A1), '0, 1'b0, 2'b00, 1'b0);
    tbl[1]  = row(mk(1'b0, 1'b1, 1'b0, 14'h0B2), '0, 1'b0, 2'b00, 1'b0);
    tbl[2]  = row('0, {mk(1'b1, 1'b0, 1'b0, 14'h0A1), mk(1'b0, 1'b1, 1'b0, 14'h0B2)}, 1'b0, 2'b01, 1'b0);
    tbl[3]  = row('0, '0, 1'b0, 2'b00, 1'b0);
    tbl[4]  = row(mk(1'b0, 1'b1, 1'b1, 14'h0C3), '0, 1'b0, 2'b00, 1'b1);
    tbl[5]  = row(mk(1'b1, 1'b0, 1'b0, 14'h0D4), '0, 1'b0, 2'b00, 1'b1);
    tbl[6]  = row(mk(1'b0, 1'b1, 1'b0, 14'h0E5), '0, 1'b0, 2'b00, 1'b1);
    tbl[7]  = row('0, {mk(1'b1, 1'b0, 1'b0, 14'h0D4), mk(1'b0, 1'b1, 1'b0, 14'h0E5)}, 1'b0, 2'b01, 1'b1);
    tbl[8]  = row('0, '0, 1'b0, 2'b00, 1'b1);
    tbl[9]  = row(mk(1'b1, 1'b1, 1'b1, 14'h0F6), '0, 1'b0, 2'b00, 1'b1);
    tbl[10] = row(mk(1'b1, 1'b0, 1'b1, 14'h107), '0, 1'b0, 2'b00, 1'b1);
    tbl[11] = row(mk(1'b1, 1'b0, 1'b1, 14'h118), '0, 1'b0, 2'b00, 1'b1);
    tbl[12] = row(mk(1'b0, 1'b1, 1'b1, 14'h129), '0, 1'b0, 2'b00, 1'b1);
    tbl[13] = row('0, {mk(1'b1, 1'b0, 1'b1, 14'h107), mk(1'b0, 1'b1, 1'b1, 14'h129)}, 1'b1, 2'b10, 1'b1);

    pkt_if.ready_in = 1'b0;
    step('0, 1'b0, 1'b1);
    check("rst_pkt", 64'(pkt_if.pkt_out), 64'(0));
    check("rst_vc", 64'(pkt_if.vc_out), 64'(0));
    check("rst_credit", 64'(credit_out), 64'(0));
    check("rst_err_protocol", 64'(err_protocol), 64'(0));
    check("rst_err_overflow", 64'(err_overflow), 64'(0));

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].flit, tbl[i].rdy, 1'b0);
      check("tbl_pkt", 64'(pkt_if.pkt_out), 64'(tbl[i].pkt));
      if (tbl[i].pkt[WP-1]) check("tbl_vc", 64'(pkt_if.vc_out), 64'(tbl[i].vc));
      check("tbl_credit", 64'(credit_out), 64'(tbl[i].cred));
      check("tbl_err_protocol", 64'(err_protocol), 64'(tbl[i].perr));
      check("tbl_err_overflow", 64'(err_overflow), 64'(tbl[i].oerr));
    end

    // Round-robin alternation with both VCs backed up
    step('0, 1'b0, 1'b1);
    step(mk(1'b1, 1'b0, 1'b0, 14'h100), 1'b0, 1'b0);
    step(mk(1'b0, 1'b1, 1'b0, 14'h101), 1'b0, 1'b0);
    step(mk(1'b1, 1'b0, 1'b1, 14'h110), 1'b0, 1'b0);
    step(mk(1'b0, 1'b1, 1'b1, 14'h111), 1'b0, 1'b0);
    step(mk(1'b1, 1'b0, 1'b0, 14'h102), 1'b0, 1'b0);
    step(mk(1'b0, 1'b1, 1'b0, 14'h103), 1'b0, 1'b0);
    step(mk(1'b1, 1'b0, 1'b1, 14'h112), 1'b0, 1'b0);
    step(mk(1'b0, 1'b1, 1'b1, 14'h113), 1'b0, 1'b0);
    step(mk(1'b1, 1'b0, 1'b0, 14'h104), 1'b0, 1'b0);
    step(mk(1'b0, 1'b1, 1'b0, 14'h105), 1'b0, 1'b0);
    if (pkt_if.pkt_out[WP-1]) order.push_back(int'(pkt_if.vc_out));
    for (int i = 0; i < 10 && order.size() < 5; i++) begin
      step('0, 1'b1, 1'b0);
      if (pkt_if.pkt_out[WP-1]) order.push_back(int'(pkt_if.vc_out));
    end
    check("rr_count", 64'(order.size()), 64'(5));
    for (int i = 0; i < 5; i++)
      check("rr_order", 64'((i < order.size()) ? order[i] : -1), 64'(exp_order[i]));

    // Backpressure holds the output and withholds credits
    step('0, 1'b0, 1'b1);
    step(mk(1'b1, 1'b0, 1'b0, 14'h200), 1'b0, 1'b0);
    step(mk(1'b0, 1'b1, 1'b0, 14'h201), 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    step(mk(1'b1, 1'b0, 1'b0, 14'h202), 1'b0, 1'b0);
    step(mk(1'b0, 1'b1, 1'b0, 14'h203), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step('0, 1'b0, 1'b0);
      check("stall_pkt", 64'(pkt_if.pkt_out),
            64'({mk(1'b1, 1'b0, 1'b0, 14'h200), mk(1'b0, 1'b1, 1'b0, 14'h201)}));
      check("stall_credit", 64'(credit_out), 64'(0));
    end
    step('0, 1'b1, 1'b0);
    check("release_pkt", 64'(pkt_if.pkt_out),
          64'({mk(1'b1, 1'b0, 1'b0, 14'h202), mk(1'b0, 1'b1, 1'b0, 14'h203)}));
    check("release_credit", 64'(credit_out), 64'(2'b01));

    // Overflow: output register parked on a VC1 packet, then BUF_DEPTH+1 packets on VC0
    step('0, 1'b0, 1'b1);
    step(mk(1'b1, 1'b0, 1'b1, 14'h300), 1'b0, 1'b0);
    step(mk(1'b0, 1'b1, 1'b1, 14'h301), 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) begin
      step(mk(1'b1, 1'b0, 1'b0, 14'h310 + 14'(2 * i)), 1'b0, 1'b0);
      step(mk(1'b0, 1'b1, 1'b0, 14'h311 + 14'(2 * i)), 1'b0, 1'b0);
    end
    check("ovf_flag", 64'(err_overflow), 64'(1));
    check("ovf_err_protocol", 64'(err_protocol), 64'(0));
    step('0, 1'b1, 1'b0);
    check("ovf_first", 64'(pkt_if.pkt_out),
          64'({mk(1'b1, 1'b0, 1'b0, 14'h310), mk(1'b0, 1'b1, 1'b0, 14'h311)}));
    step('0, 1'b1, 1'b0);
    check("ovf_second", 64'(pkt_if.pkt_out),
          64'({mk(1'b1, 1'b0, 1'b0, 14'h312), mk(1'b0, 1'b1, 1'b0, 14'h313)}));
    step('0, 1'b1, 1'b0);
    check("ovf_drained", 64'(pkt_if.pkt_out[WP-1]), 64'(0));

    // Reset with a partial packet on VC0 and buffered traffic on VC1
    step(mk(1'b1, 1'b0, 1'b1, 14'h400), 1'b0, 1'b0);
    step(mk(1'b0, 1'b1, 1'b1, 14'h401), 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    step(mk(1'b1, 1'b0, 1'b1, 14'h402), 1'b0, 1'b0);
    step(mk(1'b0, 1'b1, 1'b1, 14'h403), 1'b0, 1'b0);
    step(mk(1'b1, 1'b0, 1'b0, 14'h404), 1'b0, 1'b0);
    step('0, 1'b1, 1'b1);
    check("mid_rst_pkt", 64'(pkt_if.pkt_out), 64'(0));
    check("mid_rst_vc", 64'(pkt_if.vc_out), 64'(0));
    check("mid_rst_credit", 64'(credit_out), 64'(0));
    check("mid_rst_errors", 64'({err_protocol, err_overflow}), 64'(0));
    step('0, 1'b1, 1'b0);
    check("post_rst_idle_credit", 64'(credit_out), 64'(0));
    check("post_rst_idle_pkt", 64'(pkt_if.pkt_out), 64'(0));
    step(mk(1'b1, 1'b0, 1'b0, 14'h405), 1'b1, 1'b0);
    step(mk(1'b0, 1'b1, 1'b0, 14'h406), 1'b1, 1'b0);
    step('0, 1'b1, 1'b0);
    check("post_rst_pkt", 64'(pkt_if.pkt_out),
          64'({mk(1'b1, 1'b0, 1'b0, 14'h405), mk(1'b0, 1'b1, 1'b0, 14'h406)}));
    check("post_rst_credit", 64'(credit_out), 64'(2'b01));
    check("post_rst_err_protocol", 64'(err_protocol), 64'(0));

    step('0, 1'b0, 1'b1);
    run_random(1500, 85);
    step('0, 1'b0, 1'b1);
    run_random(1500, 15);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
